// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants and the boundaries derived from them.
package vga_pkg;

  localparam int unsigned COUNT_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int unsigned H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // Inclusive window test used for the sync pulses.
  function automatic logic in_window(input logic [COUNT_W-1:0] v,
                                     input logic [COUNT_W-1:0] lo,
                                     input logic [COUNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_controller_if.sv
// Video timing outputs towards the DAC and the colour mapper.
interface vga_controller_if;
  import vga_pkg::*;

  logic               VGA_CLK;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_BLANK_N;
  logic               VGA_SYNC_N;
  logic [COUNT_W-1:0] DrawX;
  logic [COUNT_W-1:0] DrawY;
  logic               frame_start;

  modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
                         DrawX, DrawY, frame_start);
  modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
                         DrawX, DrawY, frame_start);
endinterface

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; exposes its next value and a wrap strobe.
module mod_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next_c,
  output logic             wrap_c
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  always_comb begin
    wrap_c       = en && (count == LAST);
    count_next_c = count;
    if (en) count_next_c = wrap_c ? '0 : count + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else        count <= count_next_c;
  end

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator: pixel clock at Clk/2, pixel/line counters, syncs and blanking.
module vga_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_controller_if.master vga
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_W-1:0] H_VIS_L = COUNT_W'(H_VISIBLE);
  localparam logic [COUNT_W-1:0] V_VIS_L = COUNT_W'(V_VISIBLE);
  localparam logic [COUNT_W-1:0] HS_LO   = COUNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_HI   = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VS_LO   = COUNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_HI   = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic               phase;
  logic               hs;
  logic               vs;
  logic               blank_n;
  logic               frame_start;
  logic [COUNT_W-1:0] draw_x;
  logic [COUNT_W-1:0] draw_y;
  logic [COUNT_W-1:0] x_next;
  logic [COUNT_W-1:0] y_next;
  logic               h_wrap;
  logic               v_wrap;

  // Pixel column advances on the second Clk of every pixel.
  mod_counter #(.MODULUS(H_TOT), .WIDTH(COUNT_W)) u_h_count (
    .clk          (Clk),
    .rst_n        (Reset),
    .en           (phase),
    .count        (draw_x),
    .count_next_c (x_next),
    .wrap_c       (h_wrap)
  );

  mod_counter #(.MODULUS(V_TOT), .WIDTH(COUNT_W)) u_v_count (
    .clk          (Clk),
    .rst_n        (Reset),
    .en           (h_wrap),
    .count        (draw_y),
    .count_next_c (y_next),
    .wrap_c       (v_wrap)
  );

  // Decoding the next counter values keeps syncs/blank aligned with DrawX/DrawY.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      phase       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      phase       <= ~phase;
      hs          <= ~in_window(x_next, HS_LO, HS_HI);
      vs          <= ~in_window(y_next, VS_LO, VS_HI);
      blank_n     <= (x_next < H_VIS_L) && (y_next < V_VIS_L);
      frame_start <= h_wrap && v_wrap;
    end
  end

  assign vga.VGA_CLK     = phase;
  assign vga.VGA_HS      = hs;
  assign vga.VGA_VS      = vs;
  assign vga.VGA_BLANK_N = blank_n;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.DrawX       = draw_x;
  assign vga.DrawY       = draw_y;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller with shrunk timing so full frames fit in a short run.
module tb_vga_controller;

  localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;   // 32
  localparam int VT = VV + VF + VSW + VB;   // 19
  localparam int FRAME_CLK = 2 * HT * VT;   // 1216

  typedef struct {
    int x; int y;
    bit ph; bit hs; bit vs; bit bl; bit fs;
  } exp_t;

  typedef struct {
    int k; int x; int y;
    bit ph; bit hs; bit vs; bit bl; bit fs;
  } vec_t;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;
  int   k;

  vga_controller_if vga();

  vga_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vga)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference: everything follows from the number of Clk edges since reset release.
  function automatic exp_t model(input int edges);
    exp_t e;
    int p;
    p    = edges / 2;
    e.ph = bit'(edges % 2);
    e.x  = p % HT;
    e.y  = (p / HT) % VT;
    e.hs = !(e.x >= HV + HF && e.x < HV + HF + HSW);
    e.vs = !(e.y >= VV + VF && e.y < VV + VF + VSW);
    e.bl = (e.x < HV) && (e.y < VV);
    e.fs = (edges > 0) && (edges % FRAME_CLK == 0);
    return e;
  endfunction

  task automatic tick(input bit rst);
    Reset = rst;
    @(posedge Clk);
    if (!rst) k = 0;
    else      k = k + 1;
    @(negedge Clk);
  endtask

  task automatic check(input string name, input exp_t e);
    total = total + 1;
    if (int'(vga.DrawX) != e.x || int'(vga.DrawY) != e.y || vga.VGA_CLK != e.ph ||
        vga.VGA_HS != e.hs || vga.VGA_VS != e.vs || vga.VGA_BLANK_N != e.bl ||
        vga.frame_start != e.fs || vga.VGA_SYNC_N != 1'b0) begin
      bad = bad + 1;
      $display("FAIL %s k=%0d got x=%0d y=%0d clk=%0b hs=%0b vs=%0b bl=%0b fs=%0b sn=%0b want x=%0d y=%0d clk=%0b hs=%0b vs=%0b bl=%0b fs=%0b sn=0",
               name, k, vga.DrawX, vga.DrawY, vga.VGA_CLK, vga.VGA_HS, vga.VGA_VS,
               vga.VGA_BLANK_N, vga.frame_start, vga.VGA_SYNC_N,
               e.x, e.y, e.ph, e.hs, e.vs, e.bl, e.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  vec_t tbl[16];
  exp_t e;
  exp_t rst_e;
  int   hs_low;
  int   vs_low;
  int   fs_cnt;
  int   runlen;

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    Reset = 1'b0;

    // Hand-derived points over the first frame (k = Clk edges after release).
    tbl[0]  = '{k:0,    x:0,  y:0,  ph:0, hs:1, vs:1, bl:1, fs:0};
    tbl[1]  = '{k:1,    x:0,  y:0,  ph:1, hs:1, vs:1, bl:1, fs:0};
    tbl[2]  = '{k:2,    x:1,  y:0,  ph:0, hs:1, vs:1, bl:1, fs:0};
    tbl[3]  = '{k:31,   x:15, y:0,  ph:1, hs:1, vs:1, bl:1, fs:0};
    tbl[4]  = '{k:32,   x:16, y:0,  ph:0, hs:1, vs:1, bl:0, fs:0};
    tbl[5]  = '{k:39,   x:19, y:0,  ph:1, hs:1, vs:1, bl:0, fs:0};
    tbl[6]  = '{k:40,   x:20, y:0,  ph:0, hs:0, vs:1, bl:0, fs:0};
    tbl[7]  = '{k:51,   x:25, y:0,  ph:1, hs:0, vs:1, bl:0, fs:0};
    tbl[8]  = '{k:52,   x:26, y:0,  ph:0, hs:1, vs:1, bl:0, fs:0};
    tbl[9]  = '{k:63,   x:31, y:0,  ph:1, hs:1, vs:1, bl:0, fs:0};
    tbl[10] = '{k:64,   x:0,  y:1,  ph:0, hs:1, vs:1, bl:1, fs:0};
    tbl[11] = '{k:768,  x:0,  y:12, ph:0, hs:1, vs:1, bl:0, fs:0};
    tbl[12] = '{k:896,  x:0,  y:14, ph:0, hs:1, vs:0, bl:0, fs:0};
    tbl[13] = '{k:1024, x:0,  y:16, ph:0, hs:1, vs:1, bl:0, fs:0};
    tbl[14] = '{k:1216, x:0,  y:0,  ph:0, hs:1, vs:1, bl:1, fs:1};
    tbl[15] = '{k:1217, x:0,  y:0,  ph:1, hs:1, vs:1, bl:1, fs:0};

    rst_e = '{x:0, y:0, ph:0, hs:1, vs:1, bl:1, fs:0};

    do_reset(3);
    check("reset_state", rst_e);

    foreach (tbl[i]) begin
      while (k < tbl[i].k) tick(1'b1);
      e = '{x:tbl[i].x, y:tbl[i].y, ph:tbl[i].ph, hs:tbl[i].hs,
            vs:tbl[i].vs, bl:tbl[i].bl, fs:tbl[i].fs};
      check($sformatf("vec%0d", i), e);
    end

    // One line: HS low for 2*H_SYNC Clk and DrawX back to 0 after 2*HT Clk.
    do_reset(3);
    hs_low = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      tick(1'b1);
      if (vga.VGA_HS == 1'b0) hs_low++;
    end
    check_int("line_hs_low_clk", hs_low, 12);
    check_int("line_wrap_x", int'(vga.DrawX), 0);

    // Three frames with per-cycle model checks, pulse and VS-width counting.
    do_reset(3);
    vs_low = 0;
    fs_cnt = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      tick(1'b1);
      check("frame_run", model(k));
      if (vga.frame_start) fs_cnt++;
      if (vga.VGA_VS == 1'b0) vs_low++;
    end
    check_int("frame_start_count", fs_cnt, 3);
    check_int("vs_low_clk", vs_low, 3 * 128);

    // Mid-frame reset at x=28, y=10 while phase=1.
    do_reset(2);
    while (k < 697) tick(1'b1);
    check("pre_midreset", model(k));
    tick(1'b0);
    check("midreset", rst_e);
    tick(1'b1);
    check("midreset_rel1", model(k));
    tick(1'b1);
    check_int("midreset_first_inc", int'(vga.DrawX), 1);

    // Random runs with occasional short resets anywhere in the frame.
    for (int it = 0; it < 40; it++) begin
      runlen = $urandom_range(1, 400);
      for (int c = 0; c < runlen; c++) begin
        tick(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
        if (Reset == 1'b0) check("rand_reset", rst_e);
        else               check("rand_run", model(k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
